// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer logic: pointer width,
// Gray-to-binary decode and the full-condition compare.
package fifo_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Prefix XOR from the MSB down; zero-extended inputs decode correctly.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Full when the write Gray pointer equals the read Gray pointer with its
    // two MSBs inverted (write is exactly one lap ahead).
    function automatic logic full_match(input logic [MAX_PTR_W-1:0] wgray,
                                        input logic [MAX_PTR_W-1:0] rgray,
                                        input int                   ptr_w);
        logic [MAX_PTR_W-1:0] mask;
        mask = 32'd3 << (ptr_w - 2);
        return wgray == (rgray ^ mask);
    endfunction

endpackage

// File: rtl/Binary2Gray.sv
// Combinational binary-to-Gray encoder of configurable width.
module Binary2Gray #(
    parameter int NUM_BITS = 5
) (
    input  logic [NUM_BITS-1:0] bin_i,
    output logic [NUM_BITS-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller of the async FIFO: write pointers, read-pointer
// synchroniser, registered full and sticky overflow. Define AFULL_EN for almost_full_o.
module fifo_wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W:0]   rptr_gray_i,
    output logic              wr_accept_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [ADDR_W:0]   wptr_gray_o,
    output logic              full_o,
`ifdef AFULL_EN
    output logic              almost_full_o,
`endif
    output logic              overflow_o
);

    localparam int PTR_W = ptr_width(ADDR_W);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q, sync_d;
    logic [PTR_W-1:0] wq_rptr;

    // Producer handshake: wr_en_i is the request, wr_accept_o is the grant in
    // the same cycle; a write happens only on a cycle where both are high.
    assign wr_accept_o = wr_en_i & ~full_q;

    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
        if (s == 0) begin : g_first
            assign sync_d[s] = rptr_gray_i;
        end else begin : g_next
            assign sync_d[s] = sync_q[s-1];
        end
    end

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    Binary2Gray #(
        .NUM_BITS(PTR_W)
    ) u_b2g (
        .bin_i (wbin_d),
        .gray_o(wgray_d)
    );

    always_comb begin
        wbin_d     = wbin_q + PTR_W'(wr_accept_o);
        full_d     = full_match(32'(wgray_d), 32'(wq_rptr), PTR_W);
        overflow_d = overflow_q | (wr_en_i & full_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            sync_q     <= '0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            sync_q     <= sync_d;
        end
    end

`ifdef AFULL_EN
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] fill;
    logic             afull_q, afull_d;

    always_comb begin
        rbin_s  = PTR_W'(gray2bin(32'(wq_rptr)));
        fill    = wbin_d - rbin_s;
        afull_d = (32'(fill) >= AFULL_THRESH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign almost_full_o = afull_q;
`endif

    assign waddr_o     = wbin_q[ADDR_W-1:0];
    assign wptr_gray_o = wgray_q;
    assign full_o      = full_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Scoreboard bench for fifo_wr_ptr_ctrl (ADDR_W=4, SYNC_STAGES=2, AFULL_THRESH=12);
// almost_full_o is checked when AFULL_EN is defined.
module tb_fifo_wr_ptr_ctrl;

    typedef struct packed {
        logic       m_acc;
        logic       acc;
        logic       m_waddr;
        logic [3:0] waddr;
        logic       m_gray;
        logic [4:0] gray;
        logic       m_full;
        logic       full;
        logic       m_ovf;
        logic       ovf;
        logic       m_afull;
        logic       afull;
        logic       m_onebit;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       wr_en_i = 1'b0;
    logic [4:0] rptr_gray_i = '0;
    logic       wr_accept_o;
    logic [3:0] waddr_o;
    logic [4:0] wptr_gray_o;
    logic       full_o;
    logic       overflow_o;
`ifdef AFULL_EN
    logic       almost_full_o;
`endif

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] gray_tab [0:16];

    always #5 clk = ~clk;

    fifo_wr_ptr_ctrl #(
        .ADDR_W      (4),
        .SYNC_STAGES (2),
        .AFULL_THRESH(12)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .wr_en_i      (wr_en_i),
        .rptr_gray_i  (rptr_gray_i),
        .wr_accept_o  (wr_accept_o),
        .waddr_o      (waddr_o),
        .wptr_gray_o  (wptr_gray_o),
        .full_o       (full_o),
`ifdef AFULL_EN
        .almost_full_o(almost_full_o),
`endif
        .overflow_o   (overflow_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Negative arguments mean "don't care".
    function automatic exp_t ex(input int acc, input int waddr, input int gray, input int full,
                                input int ovf, input int afull, input bit onebit);
        exp_t e;
        e = '0;
        if (acc >= 0)   begin e.m_acc   = 1'b1; e.acc   = acc[0];       end
        if (waddr >= 0) begin e.m_waddr = 1'b1; e.waddr = waddr[3:0];   end
        if (gray >= 0)  begin e.m_gray  = 1'b1; e.gray  = gray[4:0];    end
        if (full >= 0)  begin e.m_full  = 1'b1; e.full  = full[0];      end
        if (ovf >= 0)   begin e.m_ovf   = 1'b1; e.ovf   = ovf[0];       end
        if (afull >= 0) begin e.m_afull = 1'b1; e.afull = afull[0];     end
        e.m_onebit = onebit;
        return e;
    endfunction

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic drive(input logic rst, input logic wr, input logic [4:0] rptr, input exp_t e);
        @(negedge clk);
        rst_i       = rst;
        wr_en_i     = wr;
        rptr_gray_i = rptr;
        exp_q.push_back(e);
    endtask

    // Monitor: accept is checked before the edge, registers just after it.
    initial begin
        exp_t       r;
        logic [4:0] prev_gray;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                prev_gray = wptr_gray_o;
                if (r.m_acc) check("wr_accept", 32'(wr_accept_o), 32'(r.acc));
                @(posedge clk);
                #1;
                if (r.m_waddr)  check("waddr", 32'(waddr_o), 32'(r.waddr));
                if (r.m_gray)   check("wptr_gray", 32'(wptr_gray_o), 32'(r.gray));
                if (r.m_full)   check("full", 32'(full_o), 32'(r.full));
                if (r.m_ovf)    check("overflow", 32'(overflow_o), 32'(r.ovf));
                if (r.m_onebit) check("gray_onebit", $countones(prev_gray ^ wptr_gray_o), 1);
`ifdef AFULL_EN
                if (r.m_afull)  check("almost_full", 32'(almost_full_o), 32'(r.afull));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        gray_tab = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
                     5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};

        // Reset with a pending write request.
        repeat (2) drive(1'b1, 1'b1, 5'd0, ex(-1, 0, 0, 0, 0, 0, 1'b0));

        // Fill all 16 slots; full on the 16th accepting edge.
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, 5'd0, ex(1, (i + 1) % 16, gray_tab[i+1], int'(i == 15), 0,
                                       int'(i + 1 >= 12), 1'b0));

        // Write while full: refused, overflow sets and sticks.
        drive(1'b0, 1'b1, 5'd0, ex(0, 0, 24, 1, 1, 1, 1'b0));
        drive(1'b0, 1'b0, 5'd0, ex(0, 0, 24, 1, 1, 1, 1'b0));

        // One read: full drops on the third edge, then the next write lands at 0.
        drive(1'b0, 1'b0, 5'd1, ex(0, 0, 24, 1, 1, 1, 1'b0));
        drive(1'b0, 1'b0, 5'd1, ex(0, 0, 24, 1, 1, 1, 1'b0));
        drive(1'b0, 1'b0, 5'd1, ex(0, 0, 24, 0, 1, 1, 1'b0));
        drive(1'b0, 1'b1, 5'd1, ex(1, 1, 25, 1, 1, 1, 1'b0));

        // Reset mid-burst empties the FIFO and clears overflow.
        drive(1'b1, 1'b1, 5'd1, ex(-1, 0, 0, 0, 0, 0, 1'b0));

        // 40 writes with the reader trailing close behind; Gray wraps 10000 -> 00000.
        for (int k = 1; k <= 40; k++)
            drive(1'b0, 1'b1, to_gray(k - 1),
                  ex(1, k % 16, (k == 31) ? 16 : ((k == 32) ? 0 : -1), 0, 0, 0, 1'b1));

        // Almost-full: 12 writes, then one read brings fill to 11.
        drive(1'b1, 1'b0, 5'd0, ex(-1, 0, 0, 0, 0, 0, 1'b0));
        for (int k = 1; k <= 12; k++)
            drive(1'b0, 1'b1, 5'd0, ex(1, k, gray_tab[k], 0, 0, int'(k >= 12), 1'b0));
        drive(1'b0, 1'b0, 5'd1, ex(0, 12, 10, 0, 0, 1, 1'b0));
        drive(1'b0, 1'b0, 5'd1, ex(0, 12, 10, 0, 0, 1, 1'b0));
        drive(1'b0, 1'b0, 5'd1, ex(0, 12, 10, 0, 0, 0, 1'b0));

        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
